// File: rtl/sobel_frame_writer.sv
// Sink for the Sobel pixel stream: packs 4 pixels per little-endian word, queues {addr,data}
// in a small FIFO and writes one IMG_WIDTH x IMG_HEIGHT frame to memory per start pulse.
module sobel_frame_writer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ADDR_W     = 20,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        pix_in,
  input  logic              pix_valid,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);
  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int PCW  = $clog2(NPIX + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int EW   = ADDR_W + 32;
  localparam logic [PCW-1:0] LAST_PIX = PCW'(NPIX - 1);
  localparam logic [PW:0]    DEPTH_C  = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [PCW-1:0]    pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [23:0]       pack_q, pack_d;
  logic              ovf_q, ovf_d;
  logic [PW:0]       wr_ptr_q, wr_ptr_d;
  logic [PW:0]       rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];

  logic [PW:0]       fifo_cnt;
  logic              fifo_empty, fifo_full;
  logic              word_done, push, pop;
  logic [EW-1:0]     push_entry, head;

  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == DEPTH_C);
  assign head       = mem_q[rd_ptr_q[PW-1:0]];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; DRAIN leaves on the edge that pops the last queued word
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CAPTURE;
      CAPTURE: if (pix_valid && pix_cnt_q == LAST_PIX) state_d = DRAIN;
      DRAIN:   if (wr_ptr_d == rd_ptr_d) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: pixel packing, word indexing, FIFO pointers, overflow flag
  always_comb begin
    pix_cnt_d  = pix_cnt_q;
    base_d     = base_q;
    word_idx_d = word_idx_q;
    pack_d     = pack_q;
    ovf_d      = ovf_q;
    word_done  = 1'b0;
    if (state_q == IDLE && start) begin
      base_d     = base_addr;
      pix_cnt_d  = '0;
      word_idx_d = '0;
      pack_d     = '0;
      ovf_d      = 1'b0;
    end else if (state_q == CAPTURE && pix_valid) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
      pack_d    = {pix_in, pack_q[23:8]};
      if (pix_cnt_q[1:0] == 2'd3) begin
        word_done  = 1'b1;
        word_idx_d = word_idx_q + 1'b1;
      end
    end
    pop        = !fifo_empty && wr_ready;
    push       = word_done && (!fifo_full || pop);
    if (word_done && !push) ovf_d = 1'b1;
    push_entry = {base_q + word_idx_q, pix_in, pack_q};
    wr_ptr_d   = wr_ptr_q + {{PW{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{PW{1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt_q  <= '0;
      base_q     <= '0;
      word_idx_q <= '0;
      pack_q     <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      pix_cnt_q  <= pix_cnt_d;
      base_q     <= base_d;
      word_idx_q <= word_idx_d;
      pack_q     <= pack_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= push_entry;
  end

  // Outputs
  always_comb begin
    wr_valid   = !fifo_empty;
    wr_addr    = fifo_empty ? '0 : head[EW-1:32];
    wr_data    = fifo_empty ? '0 : head[31:0];
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
    overflow   = ovf_q;
  end

endmodule
